// File: rtl/reservation_station_if.sv
// reservation_station_if: dispatch, wakeup, issue and flush signals of the reservation station
interface reservation_station_if #(
  parameter int ENTRIES   = 8,
  parameter int TAG_W     = 6,
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 32
);
  localparam int CW = $clog2(ENTRIES + 1);
  logic                   flush;
  logic                   dispatch_valid;
  logic                   dispatch_ready;
  logic [PAYLOAD_W-1:0]   dispatch_payload;
  logic [TAG_W-1:0]       dispatch_rd;
  logic [TAG_W-1:0]       dispatch_rs1_tag;
  logic                   dispatch_rs1_rdy;
  logic [DATA_W-1:0]      dispatch_rs1_val;
  logic [TAG_W-1:0]       dispatch_rs2_tag;
  logic                   dispatch_rs2_rdy;
  logic [DATA_W-1:0]      dispatch_rs2_val;
  logic [3:0]             wakeup_active;
  logic [4*TAG_W-1:0]     wakeup_tag;
  logic [4*DATA_W-1:0]    wakeup_value;
  logic                   issue_valid;
  logic                   issue_ready;
  logic [PAYLOAD_W-1:0]   issue_payload;
  logic [TAG_W-1:0]       issue_rd;
  logic [DATA_W-1:0]      issue_rs1_val;
  logic [DATA_W-1:0]      issue_rs2_val;
  logic [CW-1:0]          count;
  modport master (
    output flush, dispatch_valid, dispatch_payload, dispatch_rd,
           dispatch_rs1_tag, dispatch_rs1_rdy, dispatch_rs1_val,
           dispatch_rs2_tag, dispatch_rs2_rdy, dispatch_rs2_val,
           wakeup_active, wakeup_tag, wakeup_value, issue_ready,
    input  dispatch_ready, issue_valid, issue_payload, issue_rd,
           issue_rs1_val, issue_rs2_val, count
  );
  modport slave (
    input  flush, dispatch_valid, dispatch_payload, dispatch_rd,
           dispatch_rs1_tag, dispatch_rs1_rdy, dispatch_rs1_val,
           dispatch_rs2_tag, dispatch_rs2_rdy, dispatch_rs2_val,
           wakeup_active, wakeup_tag, wakeup_value, issue_ready,
    output dispatch_ready, issue_valid, issue_payload, issue_rd,
           issue_rs1_val, issue_rs2_val, count
  );
endinterface

// File: rtl/reservation_station.sv
// reservation_station: out-of-order issue buffer with 4-lane wakeup and oldest-ready select (optional RS_WAKEUP_BYPASS_EN)
module reservation_station #(
  parameter int ENTRIES   = 8,
  parameter int TAG_W     = 6,
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 32
) (
  input logic                 clk,
  input logic                 reset,
  reservation_station_if.slave rs
);
  localparam int IW = $clog2(ENTRIES);
  localparam int CW = $clog2(ENTRIES + 1);

  // Lowest matching lane wins; tag 0 is never a real producer.
  function automatic logic [DATA_W:0] lane_hit(
    input logic [TAG_W-1:0]    t,
    input logic [3:0]          act,
    input logic [4*TAG_W-1:0]  tags,
    input logic [4*DATA_W-1:0] vals
  );
    lane_hit = '0;
    for (int l = 3; l >= 0; l--)
      if (act[l] && t != '0 && tags[l*TAG_W +: TAG_W] == t)
        lane_hit = {1'b1, vals[l*DATA_W +: DATA_W]};
  endfunction

  logic [ENTRIES-1:0]   valid, rdy1, rdy2, r1, r2, hit1, hit2, cand, sel;
  logic [ENTRIES-1:0]   age [ENTRIES];
  logic [PAYLOAD_W-1:0] payload [ENTRIES];
  logic [TAG_W-1:0]     rd [ENTRIES], tag1 [ENTRIES], tag2 [ENTRIES];
  logic [DATA_W-1:0]    val1 [ENTRIES], val2 [ENTRIES], wv1 [ENTRIES], wv2 [ENTRIES];
  logic [DATA_W-1:0]    ev1 [ENTRIES], ev2 [ENTRIES];
  logic [CW-1:0]        count_q;
  logic [IW-1:0]        free_idx;
  logic                 disp_fire, iss_fire, dh1, dh2;
  logic [DATA_W-1:0]    dw1, dw2;

  assign rs.count          = count_q;
  assign rs.dispatch_ready = count_q < CW'(ENTRIES);
  assign disp_fire         = rs.dispatch_valid && rs.dispatch_ready && !rs.flush;
  assign iss_fire          = rs.issue_valid && rs.issue_ready;
  assign cand              = valid & r1 & r2;
  assign {dh1, dw1} = lane_hit(rs.dispatch_rs1_tag, rs.wakeup_active, rs.wakeup_tag, rs.wakeup_value);
  assign {dh2, dw2} = lane_hit(rs.dispatch_rs2_tag, rs.wakeup_active, rs.wakeup_tag, rs.wakeup_value);

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
    logic [ENTRIES-1:0] col;
    assign {hit1[e], wv1[e]} = lane_hit(tag1[e], rs.wakeup_active, rs.wakeup_tag, rs.wakeup_value);
    assign {hit2[e], wv2[e]} = lane_hit(tag2[e], rs.wakeup_active, rs.wakeup_tag, rs.wakeup_value);
`ifdef RS_WAKEUP_BYPASS_EN
    assign r1[e]  = rdy1[e] | hit1[e];
    assign r2[e]  = rdy2[e] | hit2[e];
    assign ev1[e] = rdy1[e] ? val1[e] : wv1[e];
    assign ev2[e] = rdy2[e] ? val2[e] : wv2[e];
`else
    assign r1[e]  = rdy1[e];
    assign r2[e]  = rdy2[e];
    assign ev1[e] = val1[e];
    assign ev2[e] = val2[e];
`endif
    // Column e of the age matrix: which entries are older than entry e.
    always_comb
      for (int j = 0; j < ENTRIES; j++) col[j] = age[j][e];
    assign sel[e] = cand[e] && !(|(cand & col));
  end

  // Lowest-index free slot receives the next dispatch.
  always_comb begin
    free_idx = '0;
    for (int e = ENTRIES - 1; e >= 0; e--) if (!valid[e]) free_idx = IW'(e);
  end

  // One-hot select drives the issue bus; empty select yields all zeros.
  always_comb begin
    rs.issue_valid   = |cand && !rs.flush;
    rs.issue_payload = '0;
    rs.issue_rd      = '0;
    rs.issue_rs1_val = '0;
    rs.issue_rs2_val = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      rs.issue_payload = rs.issue_payload | ({PAYLOAD_W{sel[e]}} & payload[e]);
      rs.issue_rd      = rs.issue_rd      | ({TAG_W{sel[e]}} & rd[e]);
      rs.issue_rs1_val = rs.issue_rs1_val | ({DATA_W{sel[e]}} & ev1[e]);
      rs.issue_rs2_val = rs.issue_rs2_val | ({DATA_W{sel[e]}} & ev2[e]);
    end
  end

  // Occupancy, validity and age ordering; a new entry is younger than every valid one.
  always_ff @(posedge clk or negedge reset)
    if (!reset || !rs.flush == 1'b0) begin
      valid   <= '0;
      count_q <= '0;
      for (int i = 0; i < ENTRIES; i++) age[i] <= '0;
    end else begin
      valid   <= (valid & ~(sel & {ENTRIES{iss_fire}})) | (ENTRIES'(disp_fire) << free_idx);
      count_q <= count_q + CW'(disp_fire) - CW'(iss_fire);
      if (disp_fire) begin
        for (int i = 0; i < ENTRIES; i++) age[i][free_idx] <= valid[i];
        age[free_idx] <= '0;
      end
    end

  // Entry contents: written on dispatch (capturing same-cycle wakeups), else updated by wakeup.
  always_ff @(posedge clk)
    for (int e = 0; e < ENTRIES; e++)
      if (disp_fire && free_idx == IW'(e)) begin
        payload[e] <= rs.dispatch_payload;
        rd[e]      <= rs.dispatch_rd;
        tag1[e]    <= rs.dispatch_rs1_tag;
        tag2[e]    <= rs.dispatch_rs2_tag;
        rdy1[e]    <= rs.dispatch_rs1_rdy | dh1;
        rdy2[e]    <= rs.dispatch_rs2_rdy | dh2;
        val1[e]    <= rs.dispatch_rs1_rdy ? rs.dispatch_rs1_val : dw1;
        val2[e]    <= rs.dispatch_rs2_rdy ? rs.dispatch_rs2_val : dw2;
      end else begin
        if (!rdy1[e] && hit1[e]) begin
          rdy1[e] <= 1'b1;
          val1[e] <= wv1[e];
        end
        if (!rdy2[e] && hit2[e]) begin
          rdy2[e] <= 1'b1;
          val2[e] <= wv2[e];
        end
      end
endmodule
